// File: rtl/round_key_store_if.sv
// Write-side handshake bundle between the AES-128 key-expansion source and round_key_store.
interface round_key_store_if;
  logic         start;
  logic         in_valid;
  logic [127:0] in_key;
  logic         in_ready;

  modport master (output start, output in_valid, output in_key, input in_ready);
  modport slave  (input start, input in_valid, input in_key, output in_ready);
endinterface

// File: rtl/round_key_store.sv
// Sequential 1-to-11 store for AES-128 round keys, presented in parallel to the round-key mux.
// Optional macro ROUND_KEY_ZEROIZE_EN: start also clears every key register.
module round_key_store (
  input  logic                   clk,
  input  logic                   rst_n,
  round_key_store_if.slave       bus,
  output logic [3:0]             wr_idx,
  output logic                   full,
  output logic                   ovf,
  output logic [127:0]           key0,
  output logic [127:0]           key1,
  output logic [127:0]           key2,
  output logic [127:0]           key3,
  output logic [127:0]           key4,
  output logic [127:0]           key5,
  output logic [127:0]           key6,
  output logic [127:0]           key7,
  output logic [127:0]           key8,
  output logic [127:0]           key9,
  output logic [127:0]           key10
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t       state;
  state_t       state_next;
  logic         accept;
  logic [127:0] key_regs [11];

  assign bus.in_ready = (state == LOAD) && !bus.start;
  assign accept       = bus.in_valid && bus.in_ready;
  assign full         = (state == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.start) begin
      state_next = LOAD;
    end else begin
      case (state)
        LOAD:    if (accept && wr_idx == 4'd10) state_next = FULL;
        default: state_next = state;
      endcase
    end
  end

  // Priority: reset, then start, then accept, then overrun detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx <= 4'd0;
      ovf    <= 1'b0;
    end else if (bus.start) begin
      wr_idx <= 4'd0;
      ovf    <= 1'b0;
    end else begin
      if (accept) wr_idx <= wr_idx + 4'd1;
      if (state == FULL && bus.in_valid) ovf <= 1'b1;
    end
  end

  // Accept only happens in LOAD where wr_idx is 0..10, so the compare never hits 11..15.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 11; i++) begin
      if (!rst_n) begin
        key_regs[i] <= 128'h0;
`ifdef ROUND_KEY_ZEROIZE_EN
      end else if (bus.start) begin
        key_regs[i] <= 128'h0;
`else
      end else if (bus.start) begin
        key_regs[i] <= key_regs[i];
`endif
      end else if (accept && wr_idx == 4'(i)) begin
        key_regs[i] <= bus.in_key;
      end
    end
  end

  assign key0  = key_regs[0];
  assign key1  = key_regs[1];
  assign key2  = key_regs[2];
  assign key3  = key_regs[3];
  assign key4  = key_regs[4];
  assign key5  = key_regs[5];
  assign key6  = key_regs[6];
  assign key7  = key_regs[7];
  assign key8  = key_regs[8];
  assign key9  = key_regs[9];
  assign key10 = key_regs[10];

endmodule

// File: tb/tb_round_key_store.sv
// Directed, table-driven bench for round_key_store; honours ROUND_KEY_ZEROIZE_EN when defined.
module tb_round_key_store;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   wr_idx;
  logic         full;
  logic         ovf;
  logic [127:0] k [11];

  round_key_store_if bus ();

  round_key_store dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .wr_idx(wr_idx), .full(full), .ovf(ovf),
    .key0(k[0]), .key1(k[1]), .key2(k[2]), .key3(k[3]), .key4(k[4]), .key5(k[5]),
    .key6(k[6]), .key7(k[7]), .key8(k[8]), .key9(k[9]), .key10(k[10])
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           rst_n;
    bit           start;
    bit           in_valid;
    logic [127:0] in_key;
    bit           exp_ready;
    logic [3:0]   exp_wr;
    bit           exp_full;
    bit           exp_ovf;
    int           key_sel;
    logic [127:0] exp_key;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [127:0] KEY_A = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] KEY_B = 128'h5A5A_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
  localparam logic [127:0] ONES  = {128{1'b1}};

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add_vec(bit s, bit v, logic [127:0] key, bit rdy, logic [3:0] wr,
                                  bit f, bit o, int sel, logic [127:0] ek);
    vec_t x;
    x.rst_n = 1'b1; x.start = s; x.in_valid = v; x.in_key = key;
    x.exp_ready = rdy; x.exp_wr = wr; x.exp_full = f; x.exp_ovf = o;
    x.key_sel = sel; x.exp_key = ek;
    vecs.push_back(x);
  endfunction

  // Inputs change 1 time unit after a rising edge; in_ready is checked before the next edge,
  // registered outputs 1 time unit after it.
  task automatic apply_stimulus(input vec_t x, input int n);
    rst_n        = x.rst_n;
    bus.start    = x.start;
    bus.in_valid = x.in_valid;
    bus.in_key   = x.in_key;
    #1;
    check_output($sformatf("v%0d_in_ready", n), 128'(bus.in_ready), 128'(x.exp_ready));
    @(posedge clk); #1;
    check_output($sformatf("v%0d_wr_idx", n), 128'(wr_idx), 128'(x.exp_wr));
    check_output($sformatf("v%0d_full", n), 128'(full), 128'(x.exp_full));
    check_output($sformatf("v%0d_ovf", n), 128'(ovf), 128'(x.exp_ovf));
    if (x.key_sel >= 0)
      check_output($sformatf("v%0d_key%0d", n, x.key_sel), k[x.key_sel], x.exp_key);
  endtask

  task automatic drive(input bit s, input bit v, input logic [127:0] key);
    bus.start = s; bus.in_valid = v; bus.in_key = key;
    @(posedge clk); #1;
  endtask

  logic [127:0] exp_key2;
  logic [127:0] hold [5];

  initial begin
    rst_n = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_key = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready", 128'(bus.in_ready), 128'd0);
    check_output("rst_wr_idx", 128'(wr_idx), 128'd0);
    check_output("rst_full", 128'(full), 128'd0);
    check_output("rst_ovf", 128'(ovf), 128'd0);
    for (int i = 0; i < 11; i++) check_output($sformatf("rst_key%0d", i), k[i], 128'h0);

    // Idle ignores in_valid, then full load of keys 0..10, overrun, and clearing start.
    add_vec(0, 1, ONES, 0, 4'd0, 0, 0, 0, 128'h0);
    add_vec(1, 0, '0,   0, 4'd0, 0, 0, -1, '0);
    for (int i = 0; i < 11; i++)
      add_vec(0, 1, 128'(i), 1, 4'(i + 1), (i == 10), 0, i, 128'(i));
    add_vec(0, 1, ONES, 0, 4'd11, 1, 1, 10, 128'd10);
    add_vec(0, 0, '0,   0, 4'd11, 1, 1, 0, 128'd0);
    add_vec(1, 0, '0,   0, 4'd0,  0, 0, -1, '0);
    // Gapped load.
`ifdef ROUND_KEY_ZEROIZE_EN
    exp_key2 = 128'h0;
`else
    exp_key2 = 128'd2;
`endif
    add_vec(0, 1, KEY_A, 1, 4'd1, 0, 0, 0, KEY_A);
    add_vec(0, 0, KEY_B, 1, 4'd1, 0, 0, 1, 128'd1 & {128{exp_key2 != 0}});
    add_vec(0, 1, KEY_B, 1, 4'd2, 0, 0, 1, KEY_B);
    add_vec(0, 0, ONES,  1, 4'd2, 0, 0, 2, exp_key2);

    foreach (vecs[i]) apply_stimulus(vecs[i], i);

    // Restart mid-load after five accepts: the start-cycle beat is dropped.
    for (int i = 0; i < 3; i++) drive(0, 1, 128'h100 + 128'(i));
    check_output("pre_restart_wr_idx", 128'(wr_idx), 128'd5);
    hold[0] = KEY_A; hold[1] = KEY_B;
    for (int i = 2; i < 5; i++) hold[i] = 128'h100 + 128'(i - 2);
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_key = 128'hDEAD;
    #1;
    check_output("restart_in_ready", 128'(bus.in_ready), 128'd0);
    @(posedge clk); #1;
    check_output("restart_wr_idx", 128'(wr_idx), 128'd0);
    for (int i = 0; i < 5; i++) begin
`ifdef ROUND_KEY_ZEROIZE_EN
      check_output($sformatf("restart_key%0d", i), k[i], 128'h0);
`else
      check_output($sformatf("restart_key%0d", i), k[i], hold[i]);
`endif
    end
    drive(0, 1, 128'hBEEF);
    check_output("post_restart_wr_idx", 128'(wr_idx), 128'd1);
    check_output("post_restart_key0", k[0], 128'hBEEF);
    check_output("post_restart_in_ready", 128'(bus.in_ready), 128'd1);

    // Reset after seven accepts clears everything.
    drive(1, 0, '0);
    for (int i = 0; i < 7; i++) drive(0, 1, 128'h200 + 128'(i));
    check_output("pre_reset_wr_idx", 128'(wr_idx), 128'd7);
    check_output("pre_reset_key6", k[6], 128'h206);
    rst_n = 1'b0;
    drive(0, 1, ONES);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    #1;
    check_output("mid_reset_in_ready", 128'(bus.in_ready), 128'd0);
    check_output("mid_reset_wr_idx", 128'(wr_idx), 128'd0);
    check_output("mid_reset_full", 128'(full), 128'd0);
    check_output("mid_reset_ovf", 128'(ovf), 128'd0);
    for (int i = 0; i < 11; i++) check_output($sformatf("mid_reset_key%0d", i), k[i], 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
